// File: rtl/ppu_clock_monitor.sv
// ppu_clock_monitor: synchronises a slow external clock and times its phases.
// Optional min/max period statistics are enabled by defining PPU_CLKMON_STATS_EN.
module ppu_clock_monitor #(
   parameter int SYNC_STAGES     = 2,
   parameter int PERIOD_BITS     = 16,
   parameter int TIMEOUT_CYCLES  = 64,
   parameter int MIN_HALF_CYCLES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clk_i,
   input  logic                   clear_i,
   output logic                   clk_sync_o,
   output logic                   rise_o,
   output logic                   fall_o,
   output logic [31:0]            edge_counter_o,
   output logic [PERIOD_BITS-1:0] high_len_o,
   output logic [PERIOD_BITS-1:0] low_len_o,
   output logic                   period_valid_o,
   output logic                   running_o,
   output logic                   stopped_o,
   output logic                   glitch_o,
   output logic [PERIOD_BITS-1:0] min_period_o,
   output logic [PERIOD_BITS-1:0] max_period_o
);

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      RUN,
      STOPPED
   } state_t;

   localparam logic [PERIOD_BITS-1:0] ALL_ONES = '1;
   localparam logic [PERIOD_BITS-1:0] TIMEOUT  = PERIOD_BITS'(TIMEOUT_CYCLES);
   localparam logic [PERIOD_BITS-1:0] MIN_HALF = PERIOD_BITS'(MIN_HALF_CYCLES);

   state_t                 state_q;
   state_t                 state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_d1_q;
   logic                   rise_q;
   logic                   fall_q;
   logic [PERIOD_BITS-1:0] phase_cnt_q;
   logic [PERIOD_BITS-1:0] phase_len;
   logic                   got_high_q;
   logic                   got_low_q;
   logic                   edge_seen;
   logic                   capture;
   logic                   timed_out;

   assign clk_sync_o     = sync_q[SYNC_STAGES-1];
   assign rise_o         = rise_q;
   assign fall_o         = fall_q;
   assign edge_seen      = rise_q | fall_q;
   assign timed_out      = (phase_cnt_q == TIMEOUT);
   assign period_valid_o = got_high_q & got_low_q;
   assign running_o      = (state_q == RUN);
   assign stopped_o      = (state_q == STOPPED);

   // saturating phase_cnt+1: both the running count and the captured length
   assign phase_len = (phase_cnt_q == ALL_ONES) ? ALL_ONES
                                                : phase_cnt_q + PERIOD_BITS'(1);

   // a clear on the edge cycle swallows that edge entirely
   assign capture = edge_seen & ~clear_i
                  & ((state_q == ARMED) | (state_q == RUN));

   // input synchroniser followed by registered one-cycle edge pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q    <= '0;
         sync_d1_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], clk_i};
         sync_d1_q <= sync_q[SYNC_STAGES-1];
         rise_q    <= sync_q[SYNC_STAGES-1] & ~sync_d1_q;
         fall_q    <= ~sync_q[SYNC_STAGES-1] & sync_d1_q;
      end
   end

   // state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state: edges advance the monitor, a long quiet phase stops it
   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (edge_seen) state_d = ARMED;
            end
            ARMED: begin
               if (edge_seen) state_d = RUN;
               else if (timed_out) state_d = STOPPED;
            end
            RUN: begin
               if (!edge_seen && timed_out) state_d = STOPPED;
            end
            STOPPED: begin
               if (edge_seen) state_d = ARMED;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // phase timing, edge counting, length capture and glitch flag
   always_ff @(posedge clock) begin
      if (reset || clear_i) begin
         phase_cnt_q    <= '0;
         edge_counter_o <= '0;
         high_len_o     <= '0;
         low_len_o      <= '0;
         got_high_q     <= 1'b0;
         got_low_q      <= 1'b0;
         glitch_o       <= 1'b0;
      end else begin
         phase_cnt_q <= edge_seen ? '0 : phase_len;
         if (fall_q) edge_counter_o <= edge_counter_o + 32'd1;
         if (capture) begin
            if (fall_q) begin
               high_len_o <= phase_len;
               got_high_q <= 1'b1;
            end
            if (rise_q) begin
               low_len_o <= phase_len;
               got_low_q <= 1'b1;
            end
            if (phase_len < MIN_HALF) glitch_o <= 1'b1;
         end
         if (state_d == STOPPED) begin
            got_high_q <= 1'b0;
            got_low_q  <= 1'b0;
         end
      end
   end

`ifdef PPU_CLKMON_STATS_EN
   logic [PERIOD_BITS-1:0] high_new;
   logic [PERIOD_BITS-1:0] low_new;
   logic [PERIOD_BITS-1:0] period;
   logic [PERIOD_BITS:0]   period_sum;
   logic                   valid_new;

   // period as it will read after this cycle's capture
   always_comb begin
      high_new   = fall_q ? phase_len : high_len_o;
      low_new    = rise_q ? phase_len : low_len_o;
      valid_new  = (got_high_q | fall_q) & (got_low_q | rise_q);
      period_sum = {1'b0, high_new} + {1'b0, low_new};
      period     = period_sum[PERIOD_BITS] ? ALL_ONES
                                           : period_sum[PERIOD_BITS-1:0];
   end

   // running min/max of complete periods
   always_ff @(posedge clock) begin
      if (reset || clear_i) begin
         min_period_o <= ALL_ONES;
         max_period_o <= '0;
      end else if (capture && valid_new) begin
         if (period < min_period_o) min_period_o <= period;
         if (period > max_period_o) max_period_o <= period;
      end
   end
`else
   assign min_period_o = ALL_ONES;
   assign max_period_o = '0;
`endif

endmodule

// File: tb/tb_ppu_clock_monitor.sv
// tb_ppu_clock_monitor: random and directed clk_i waveforms checked
// against a phase-level model of the monitor.
module tb_ppu_clock_monitor;

   localparam int PB   = 16;
   localparam int TMO  = 64;
   localparam int SYNC = 2;

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic          clk_i   = 1'b0;
   logic          clear_i = 1'b0;
   logic          clk_sync_o;
   logic          rise_o;
   logic          fall_o;
   logic [31:0]   edge_counter_o;
   logic [PB-1:0] high_len_o;
   logic [PB-1:0] low_len_o;
   logic          period_valid_o;
   logic          running_o;
   logic          stopped_o;
   logic          glitch_o;
   logic [PB-1:0] min_period_o;
   logic [PB-1:0] max_period_o;

   ppu_clock_monitor #(
      .SYNC_STAGES    (SYNC),
      .PERIOD_BITS    (PB),
      .TIMEOUT_CYCLES (TMO),
      .MIN_HALF_CYCLES(2)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .clk_i         (clk_i),
      .clear_i       (clear_i),
      .clk_sync_o    (clk_sync_o),
      .rise_o        (rise_o),
      .fall_o        (fall_o),
      .edge_counter_o(edge_counter_o),
      .high_len_o    (high_len_o),
      .low_len_o     (low_len_o),
      .period_valid_o(period_valid_o),
      .running_o     (running_o),
      .stopped_o     (stopped_o),
      .glitch_o      (glitch_o),
      .min_period_o  (min_period_o),
      .max_period_o  (max_period_o)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   typedef enum int {M_IDLE, M_ARMED, M_RUN, M_STOP} mst_t;

   mst_t        m_st;
   logic [31:0] m_cnt;
   int          m_hi, m_lo, m_min, m_max;
   bit          m_gh, m_gl, m_glitch;
   logic        cur;
   int          since;
   logic        s_rise, s_fall, s_stop;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_clear();
      m_st     = M_IDLE;
      m_cnt    = '0;
      m_hi     = 0;
      m_lo     = 0;
      m_gh     = 0;
      m_gl     = 0;
      m_glitch = 0;
      m_min    = 65535;
      m_max    = 0;
   endtask

   // one clk_i transition ending a phase of len cycles
   task automatic m_edge(input logic lvl, input int len);
      int l;
      int p;
      l = (len > 65535) ? 65535 : len;
      if (!lvl) m_cnt = m_cnt + 32'd1;
      if (m_st == M_IDLE || m_st == M_STOP) begin
         m_st = M_ARMED;
      end else begin
         if (!lvl) begin
            m_hi = l;
            m_gh = 1;
         end else begin
            m_lo = l;
            m_gl = 1;
         end
         if (l < 2) m_glitch = 1;
         m_st = M_RUN;
         if (m_gh && m_gl) begin
            p = m_hi + m_lo;
            if (p > 65535) p = 65535;
            if (p < m_min) m_min = p;
            if (p > m_max) m_max = p;
         end
      end
   endtask

   // one system cycle of stimulus; a gap of TMO+2 cycles between clk_i
   // transitions is the shortest one the monitor reports as stopped
   task automatic cyc(input logic v, input logic clr);
      @(negedge clock);
      s_rise  = rise_o;
      s_fall  = fall_o;
      s_stop  = stopped_o;
      clear_i = clr;
      if (v !== cur) begin
         m_edge(v, since);
         since = 0;
         cur   = v;
      end
      clk_i = v;
      since++;
      if (clr) m_clear();
      if ((m_st == M_ARMED || m_st == M_RUN) && since >= TMO + 2) begin
         m_st = M_STOP;
         m_gh = 0;
         m_gl = 0;
      end
   endtask

   task automatic period(input int h, input int l);
      repeat (h) cyc(1'b1, 1'b0);
      repeat (l) cyc(1'b0, 1'b0);
   endtask

   task automatic hold(input int n);
      repeat (n) cyc(1'b0, 1'b0);
   endtask

   task automatic checkpoint(input string tag);
      chk({tag, ".cnt"}, edge_counter_o, m_cnt);
      chk({tag, ".high"}, 32'(high_len_o), 32'(m_hi));
      chk({tag, ".low"}, 32'(low_len_o), 32'(m_lo));
      chk({tag, ".valid"}, 32'(period_valid_o), 32'(m_gh && m_gl));
      chk({tag, ".run"}, 32'(running_o), 32'(m_st == M_RUN));
      chk({tag, ".stop"}, 32'(stopped_o), 32'(m_st == M_STOP));
      chk({tag, ".glitch"}, 32'(glitch_o), 32'(m_glitch));
      chk({tag, ".sync"}, 32'(clk_sync_o), 32'(cur));
`ifdef PPU_CLKMON_STATS_EN
      chk({tag, ".min"}, 32'(min_period_o), 32'(m_min));
      chk({tag, ".max"}, 32'(max_period_o), 32'(m_max));
`else
      chk({tag, ".min"}, 32'(min_period_o), 32'hffff);
      chk({tag, ".max"}, 32'(max_period_o), 32'h0);
`endif
   endtask

   function automatic int pick_len();
      if ($urandom_range(0, 11) == 0) return 1;
      return int'($urandom_range(2, 12));
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      m_clear();
      cur   = 1'b0;
      since = 0;
      repeat (3) @(negedge clock);
      checkpoint("reset");
      chk("reset.rise", 32'(rise_o), 32'h0);
      chk("reset.fall", 32'(fall_o), 32'h0);
      reset = 1'b0;

      // T1: 5/5 stream, edge latency and steady lengths
      for (int p = 0; p < 20; p++) begin
         for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0);
            if (p == 0 && k == SYNC) chk("t1.rise_early", 32'(s_rise), 32'h0);
            if (p == 0 && k == SYNC + 1) chk("t1.rise_lat", 32'(s_rise), 32'h1);
         end
         repeat (5) cyc(1'b0, 1'b0);
      end
      hold(6);
      checkpoint("t1");
      chk("t1.cnt20", edge_counter_o, 32'd20);
      chk("t1.high5", 32'(high_len_o), 32'd5);
      chk("t1.low5", 32'(low_len_o), 32'd5);

      // T2: stop detection timing, then restart
      repeat (2) period(5, 5);
      repeat (5) cyc(1'b1, 1'b0);
      for (int k = 0; k < 76; k++) begin
         cyc(1'b0, 1'b0);
         if (k == SYNC + TMO + 2) chk("t2.stop_early", 32'(s_stop), 32'h0);
         if (k == SYNC + TMO + 3) chk("t2.stop_at", 32'(s_stop), 32'h1);
      end
      checkpoint("t2.stopped");
      repeat (6) cyc(1'b1, 1'b0);
      checkpoint("t2.armed");
      hold(6);
      checkpoint("t2.run");

      // T3: one-cycle high pulse sets a sticky glitch
      repeat (3) period(5, 5);
      period(1, 6);
      checkpoint("t3.pulse");
      chk("t3.high1", 32'(high_len_o), 32'd1);
      repeat (4) period(5, 5);
      hold(6);
      checkpoint("t3.sticky");
      cyc(1'b0, 1'b1);
      hold(3);
      checkpoint("t3.clr");

      // T4: clear coincident with fall_o
      repeat (2) period(5, 5);
      repeat (5) cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      chk("t4.fall_pulse", 32'(s_fall), 32'h1);
      hold(4);
      checkpoint("t4.clr");
      chk("t4.cnt0", edge_counter_o, 32'd0);
      period(5, 5);
      hold(6);
      checkpoint("t4.after");
      chk("t4.cnt1", edge_counter_o, 32'd1);

      // T6: stats over periods 10, 14, 8
      cyc(1'b0, 1'b1);
      hold(3);
      period(5, 5);
      period(7, 7);
      period(4, 4);
      repeat (4) cyc(1'b1, 1'b0);
      hold(6);
      checkpoint("t6");
`ifdef PPU_CLKMON_STATS_EN
      chk("t6.min8", 32'(min_period_o), 32'd8);
      chk("t6.max14", 32'(max_period_o), 32'd14);
`else
      chk("t6.min_tied", 32'(min_period_o), 32'hffff);
      chk("t6.max_tied", 32'(max_period_o), 32'h0);
`endif

      // T5: reset mid-run, then resume
      repeat (3) period(5, 5);
      hold(6);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      m_clear();
      since = 0;
      checkpoint("t5.reset");
      chk("t5.rise", 32'(rise_o), 32'h0);
      chk("t5.fall", 32'(fall_o), 32'h0);
      reset = 1'b0;
      repeat (3) period(5, 5);
      hold(6);
      checkpoint("t5.resume");

      // random bursts with occasional clears and stops
      for (int it = 0; it < 40; it++) begin
         int n;
         int r;
         n = int'($urandom_range(1, 6));
         repeat (n) period(pick_len(), pick_len());
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            hold(int'($urandom_range(75, 90)));
         end else if (r == 1) begin
            hold(6);
            cyc(1'b0, 1'b1);
            hold(3);
         end else begin
            hold(int'($urandom_range(6, 10)));
         end
         checkpoint("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
